cv32e40p_rf_wb_arbiter: RTL and testbench



---
 rtl/cv32e40p_pkg.sv | 27 ++
 rtl/cv32e40p_rf_wb_arbiter_if.sv | 49 ++++
 rtl/cv32e40p_rf_wb_arbiter_skid_fifo.sv | 57 +++++
 rtl/cv32e40p_rf_wb_arbiter.sv | 121 ++++++++++++
 tb/tb_cv32e40p_rf_wb_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/cv32e40p_pkg.sv
// rtl/cv32e40p_pkg.sv - shared register-file writeback types, constants and address check
package cv32e40p_pkg;

    localparam int RF_FP_BANK_BIT = 5;
    localparam int RF_ADDR_WIDTH  = 6;
    localparam int RF_DATA_WIDTH  = 32;

    typedef struct packed {
        logic                     valid;
        logic [RF_ADDR_WIDTH-1:0] waddr;
        logic [RF_DATA_WIDTH-1:0] wdata;
    } rf_wb_req_t;

    typedef enum logic {
        GRANT_LSU = 1'b0,
        GRANT_APU = 1'b1
    } rf_wb_grant_e;

    // x0 is hardwired and the FP bank only exists when it is physically present
    function automatic logic rf_waddr_legal(
        input logic [RF_ADDR_WIDTH-1:0] waddr,
        input logic                     fp_bank_en
    );
        return (waddr != '0) && (fp_bank_en || !waddr[RF_FP_BANK_BIT]);
    endfunction

endpackage

// File: rtl/cv32e40p_rf_wb_arbiter_if.sv
// rtl/cv32e40p_rf_wb_arbiter_if.sv - writeback source handshakes and register-file write ports
interface cv32e40p_rf_wb_arbiter_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);

    logic                  ex_we_i;
    logic [ADDR_WIDTH-1:0] ex_waddr_i;
    logic [DATA_WIDTH-1:0] ex_wdata_i;

    logic                  lsu_valid_i;
    logic                  lsu_ready_o;
    logic [ADDR_WIDTH-1:0] lsu_waddr_i;
    logic [DATA_WIDTH-1:0] lsu_wdata_i;

    logic                  apu_valid_i;
    logic                  apu_ready_o;
    logic [ADDR_WIDTH-1:0] apu_waddr_i;
    logic [DATA_WIDTH-1:0] apu_wdata_i;

    logic                  rf_we_a_o;
    logic [ADDR_WIDTH-1:0] rf_waddr_a_o;
    logic [DATA_WIDTH-1:0] rf_wdata_a_o;
    logic                  rf_we_b_o;
    logic [ADDR_WIDTH-1:0] rf_waddr_b_o;
    logic [DATA_WIDTH-1:0] rf_wdata_b_o;
    logic                  collision_o;

    modport master (
        output ex_we_i, ex_waddr_i, ex_wdata_i,
        output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        output apu_valid_i, apu_waddr_i, apu_wdata_i,
        input  lsu_ready_o, apu_ready_o,
        input  rf_we_a_o, rf_waddr_a_o, rf_wdata_a_o,
        input  rf_we_b_o, rf_waddr_b_o, rf_wdata_b_o,
        input  collision_o
    );

    modport slave (
        input  ex_we_i, ex_waddr_i, ex_wdata_i,
        input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        input  apu_valid_i, apu_waddr_i, apu_wdata_i,
        output lsu_ready_o, apu_ready_o,
        output rf_we_a_o, rf_waddr_a_o, rf_wdata_a_o,
        output rf_we_b_o, rf_waddr_b_o, rf_wdata_b_o,
        output collision_o
    );

endinterface

// File: rtl/cv32e40p_rf_wb_arbiter_skid_fifo.sv
// rtl/cv32e40p_rf_wb_arbiter_skid_fifo.sv - two-entry valid/ready FIFO decoupling APU results from port-B arbitration
module cv32e40p_rf_wb_skid_fifo #(
    parameter int WIDTH = 38
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             push, pop;

    // Ready depends only on occupancy so the APU never waits on arbitration
    assign s_tready = (count_q != 2'd2) && !rst;
    assign m_tvalid = (count_q != 2'd0);
    assign m_tdata  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        push     = s_tvalid && s_tready;
        pop      = m_tvalid && m_tready;
        if (push) begin
            mem_d[wr_ptr_q] = s_tdata;
            wr_ptr_d        = !wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cv32e40p_rf_wb_arbiter.sv
// rtl/cv32e40p_rf_wb_arbiter.sv - merges EX, LSU and APU results onto two register-file write ports
// Optional APU skid FIFO: CV32E40P_WB_ARB_APU_SKID_EN
module cv32e40p_rf_wb_arbiter
    import cv32e40p_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter bit FPU        = 1'b1,
    parameter bit ZFINX      = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst,
    cv32e40p_rf_wb_arbiter_if.slave        bus
);

    localparam bit FP_BANK_EN = FPU && !ZFINX;

    rf_wb_req_t      lsu_req;
    rf_wb_req_t      apu_req;
    rf_wb_grant_e    last_grant_q, last_grant_d;
    logic            gnt_lsu, gnt_apu;
    logic            b_fire, b_legal, b_collide;
    logic [ADDR_WIDTH-1:0] b_waddr;
    logic [DATA_WIDTH-1:0] b_wdata;

    logic                  rf_we_a_q, rf_we_a_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_a_q, rf_waddr_a_d;
    logic [DATA_WIDTH-1:0] rf_wdata_a_q, rf_wdata_a_d;
    logic                  rf_we_b_q, rf_we_b_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_b_q, rf_waddr_b_d;
    logic [DATA_WIDTH-1:0] rf_wdata_b_q, rf_wdata_b_d;
    logic                  collision_q, collision_d;

    assign lsu_req = '{valid: bus.lsu_valid_i, waddr: bus.lsu_waddr_i, wdata: bus.lsu_wdata_i};

`ifdef CV32E40P_WB_ARB_APU_SKID_EN
    logic                             apu_head_valid;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] apu_head_data;
    logic                             apu_s_tready;

    cv32e40p_rf_wb_skid_fifo #(
        .WIDTH(ADDR_WIDTH + DATA_WIDTH)
    ) u_apu_skid (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (bus.apu_valid_i),
        .s_tready (apu_s_tready),
        .s_tdata  ({bus.apu_waddr_i, bus.apu_wdata_i}),
        .m_tvalid (apu_head_valid),
        .m_tready (gnt_apu),
        .m_tdata  (apu_head_data)
    );

    assign apu_req = '{valid: apu_head_valid,
                       waddr: apu_head_data[DATA_WIDTH +: ADDR_WIDTH],
                       wdata: apu_head_data[DATA_WIDTH-1:0]};
    assign bus.apu_ready_o = apu_s_tready;
`else
    assign apu_req = '{valid: bus.apu_valid_i, waddr: bus.apu_waddr_i, wdata: bus.apu_wdata_i};
    assign bus.apu_ready_o = gnt_apu && !rst;
`endif

    assign bus.lsu_ready_o = gnt_lsu && !rst;

    always_comb begin
        // Round robin on port B: the flag only moves when both sources compete
        gnt_lsu      = lsu_req.valid && (!apu_req.valid || (last_grant_q == GRANT_APU));
        gnt_apu      = apu_req.valid && !gnt_lsu;
        last_grant_d = last_grant_q;
        if (lsu_req.valid && apu_req.valid) begin
            last_grant_d = gnt_lsu ? GRANT_LSU : GRANT_APU;
        end

        b_fire    = gnt_lsu || gnt_apu;
        b_waddr   = gnt_lsu ? lsu_req.waddr : apu_req.waddr;
        b_wdata   = gnt_lsu ? lsu_req.wdata : apu_req.wdata;
        b_legal   = rf_waddr_legal(b_waddr, FP_BANK_EN);
        // EX is younger than anything on port B, so its write wins the address
        b_collide = b_fire && b_legal && bus.ex_we_i && (bus.ex_waddr_i == b_waddr);

        rf_we_a_d    = bus.ex_we_i && rf_waddr_legal(bus.ex_waddr_i, FP_BANK_EN);
        rf_waddr_a_d = bus.ex_waddr_i;
        rf_wdata_a_d = bus.ex_wdata_i;

        rf_we_b_d    = b_fire && b_legal && !b_collide;
        rf_waddr_b_d = b_fire ? b_waddr : rf_waddr_b_q;
        rf_wdata_b_d = b_fire ? b_wdata : rf_wdata_b_q;
        collision_d  = b_collide;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GRANT_APU;
            rf_we_a_q    <= 1'b0;
            rf_waddr_a_q <= '0;
            rf_wdata_a_q <= '0;
            rf_we_b_q    <= 1'b0;
            rf_waddr_b_q <= '0;
            rf_wdata_b_q <= '0;
            collision_q  <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_we_a_q    <= rf_we_a_d;
            rf_waddr_a_q <= rf_waddr_a_d;
            rf_wdata_a_q <= rf_wdata_a_d;
            rf_we_b_q    <= rf_we_b_d;
            rf_waddr_b_q <= rf_waddr_b_d;
            rf_wdata_b_q <= rf_wdata_b_d;
            collision_q  <= collision_d;
        end
    end

    assign bus.rf_we_a_o    = rf_we_a_q;
    assign bus.rf_waddr_a_o = rf_waddr_a_q;
    assign bus.rf_wdata_a_o = rf_wdata_a_q;
    assign bus.rf_we_b_o    = rf_we_b_q;
    assign bus.rf_waddr_b_o = rf_waddr_b_q;
    assign bus.rf_wdata_b_o = rf_wdata_b_q;
    assign bus.collision_o  = collision_q;

endmodule

// File: tb/tb_cv32e40p_rf_wb_arbiter.sv
// tb/tb_cv32e40p_rf_wb_arbiter.sv - directed self-checking bench for the writeback arbiter
module tb_cv32e40p_rf_wb_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    cv32e40p_rf_wb_arbiter_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

    cv32e40p_rf_wb_arbiter #(
        .ADDR_WIDTH (6),
        .DATA_WIDTH (32),
        .FPU        (1'b0),
        .ZFINX      (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic idle();
        bus.ex_we_i     = 1'b0; bus.ex_waddr_i  = '0; bus.ex_wdata_i  = '0;
        bus.lsu_valid_i = 1'b0; bus.lsu_waddr_i = '0; bus.lsu_wdata_i = '0;
        bus.apu_valid_i = 1'b0; bus.apu_waddr_i = '0; bus.apu_wdata_i = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        bus.lsu_valid_i = 1'b1; bus.lsu_waddr_i = 6'd3;
        bus.apu_valid_i = 1'b1; bus.apu_waddr_i = 6'd4;
        repeat (2) @(negedge clk);
        checks++; if (bus.rf_we_a_o !== 1'b0)     begin errors++; $display("FAIL rst_we_a got=%0b exp=0", bus.rf_we_a_o); end
        checks++; if (bus.rf_we_b_o !== 1'b0)     begin errors++; $display("FAIL rst_we_b got=%0b exp=0", bus.rf_we_b_o); end
        checks++; if (bus.rf_waddr_a_o !== 6'd0)  begin errors++; $display("FAIL rst_waddr_a got=%0h exp=0", bus.rf_waddr_a_o); end
        checks++; if (bus.rf_waddr_b_o !== 6'd0)  begin errors++; $display("FAIL rst_waddr_b got=%0h exp=0", bus.rf_waddr_b_o); end
        checks++; if (bus.rf_wdata_a_o !== 32'd0) begin errors++; $display("FAIL rst_wdata_a got=%0h exp=0", bus.rf_wdata_a_o); end
        checks++; if (bus.rf_wdata_b_o !== 32'd0) begin errors++; $display("FAIL rst_wdata_b got=%0h exp=0", bus.rf_wdata_b_o); end
        checks++; if (bus.collision_o !== 1'b0)   begin errors++; $display("FAIL rst_collision got=%0b exp=0", bus.collision_o); end
        checks++; if (bus.lsu_ready_o !== 1'b0)   begin errors++; $display("FAIL rst_lsu_ready got=%0b exp=0", bus.lsu_ready_o); end
        checks++; if (bus.apu_ready_o !== 1'b0)   begin errors++; $display("FAIL rst_apu_ready got=%0b exp=0", bus.apu_ready_o); end
        idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lsu_only();
        @(negedge clk);
        bus.lsu_valid_i = 1'b1; bus.lsu_waddr_i = 6'd5; bus.lsu_wdata_i = 32'hDEADBEEF;
        #1;
        checks++; if (bus.lsu_ready_o !== 1'b1) begin errors++; $display("FAIL lsu_only_ready got=%0b exp=1", bus.lsu_ready_o); end
        checks++; if (bus.apu_ready_o !== 1'b0) begin errors++; $display("FAIL lsu_only_apu_ready got=%0b exp=0", bus.apu_ready_o); end
        @(negedge clk);
        checks++; if (bus.rf_we_b_o !== 1'b1)           begin errors++; $display("FAIL lsu_only_we_b got=%0b exp=1", bus.rf_we_b_o); end
        checks++; if (bus.rf_waddr_b_o !== 6'd5)        begin errors++; $display("FAIL lsu_only_waddr_b got=%0h exp=5", bus.rf_waddr_b_o); end
        checks++; if (bus.rf_wdata_b_o !== 32'hDEADBEEF) begin errors++; $display("FAIL lsu_only_wdata_b got=%0h exp=deadbeef", bus.rf_wdata_b_o); end
        checks++; if (bus.rf_we_a_o !== 1'b0)           begin errors++; $display("FAIL lsu_only_we_a got=%0b exp=0", bus.rf_we_a_o); end
        idle();
        #1;
        checks++; if (bus.lsu_ready_o !== 1'b0) begin errors++; $display("FAIL lsu_only_ready_idle got=%0b exp=0", bus.lsu_ready_o); end
        @(negedge clk);
        checks++; if (bus.rf_we_b_o !== 1'b0) begin errors++; $display("FAIL lsu_only_single_we got=%0b exp=0", bus.rf_we_b_o); end
    endtask

    task automatic test_round_robin();
        int   lsu_n = 0;
        int   apu_n = 0;
        logic exp_lsu;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.lsu_valid_i = 1'b1; bus.lsu_waddr_i = 6'd1; bus.lsu_wdata_i = 32'h1000 + lsu_n;
            bus.apu_valid_i = 1'b1; bus.apu_waddr_i = 6'd2; bus.apu_wdata_i = 32'h2000 + apu_n;
            exp_lsu = ((i % 2) == 0);
            #1;
            checks++; if (bus.lsu_ready_o !== exp_lsu)  begin errors++; $display("FAIL rr_lsu_ready[%0d] got=%0b exp=%0b", i, bus.lsu_ready_o, exp_lsu); end
            checks++; if (bus.apu_ready_o !== !exp_lsu) begin errors++; $display("FAIL rr_apu_ready[%0d] got=%0b exp=%0b", i, bus.apu_ready_o, !exp_lsu); end
            @(negedge clk);
            checks++; if (bus.rf_we_b_o !== 1'b1) begin errors++; $display("FAIL rr_we_b[%0d] got=%0b exp=1", i, bus.rf_we_b_o); end
            checks++; if (bus.rf_waddr_b_o !== (exp_lsu ? 6'd1 : 6'd2)) begin errors++; $display("FAIL rr_waddr_b[%0d] got=%0h exp=%0h", i, bus.rf_waddr_b_o, exp_lsu ? 6'd1 : 6'd2); end
            checks++; if (bus.rf_wdata_b_o !== (exp_lsu ? 32'h1000 + lsu_n : 32'h2000 + apu_n)) begin errors++; $display("FAIL rr_wdata_b[%0d] got=%0h", i, bus.rf_wdata_b_o); end
            if (exp_lsu) lsu_n++; else apu_n++;
        end
        idle();
    endtask

    task automatic test_collision();
        @(negedge clk);
        bus.ex_we_i = 1'b1; bus.ex_waddr_i = 6'd7; bus.ex_wdata_i = 32'hA5A5A5A5;
        bus.lsu_valid_i = 1'b1; bus.lsu_waddr_i = 6'd7; bus.lsu_wdata_i = 32'h5A5A5A5A;
        #1;
        checks++; if (bus.lsu_ready_o !== 1'b1) begin errors++; $display("FAIL col_lsu_ready got=%0b exp=1", bus.lsu_ready_o); end
        @(negedge clk);
        checks++; if (bus.rf_we_a_o !== 1'b1)           begin errors++; $display("FAIL col_we_a got=%0b exp=1", bus.rf_we_a_o); end
        checks++; if (bus.rf_waddr_a_o !== 6'd7)        begin errors++; $display("FAIL col_waddr_a got=%0h exp=7", bus.rf_waddr_a_o); end
        checks++; if (bus.rf_wdata_a_o !== 32'hA5A5A5A5) begin errors++; $display("FAIL col_wdata_a got=%0h exp=a5a5a5a5", bus.rf_wdata_a_o); end
        checks++; if (bus.rf_we_b_o !== 1'b0)           begin errors++; $display("FAIL col_we_b got=%0b exp=0", bus.rf_we_b_o); end
        checks++; if (bus.collision_o !== 1'b1)         begin errors++; $display("FAIL col_pulse got=%0b exp=1", bus.collision_o); end
        idle();
        @(negedge clk);
        checks++; if (bus.collision_o !== 1'b0) begin errors++; $display("FAIL col_pulse_end got=%0b exp=0", bus.collision_o); end
        checks++; if (bus.rf_we_a_o !== 1'b0)   begin errors++; $display("FAIL col_we_a_end got=%0b exp=0", bus.rf_we_a_o); end
`ifndef CV32E40P_WB_ARB_APU_SKID_EN
        // Contested grant that also collides must still advance the round robin
        bus.ex_we_i = 1'b1; bus.ex_waddr_i = 6'd9; bus.ex_wdata_i = 32'h99;
        bus.lsu_valid_i = 1'b1; bus.lsu_waddr_i = 6'd9;  bus.lsu_wdata_i = 32'h900;
        bus.apu_valid_i = 1'b1; bus.apu_waddr_i = 6'd12; bus.apu_wdata_i = 32'hC00;
        #1;
        checks++; if (bus.lsu_ready_o !== 1'b1) begin errors++; $display("FAIL colrr_lsu_ready got=%0b exp=1", bus.lsu_ready_o); end
        @(negedge clk);
        checks++; if (bus.collision_o !== 1'b1) begin errors++; $display("FAIL colrr_pulse got=%0b exp=1", bus.collision_o); end
        bus.ex_we_i = 1'b0;
        bus.lsu_waddr_i = 6'd10; bus.lsu_wdata_i = 32'hA00;
        #1;
        checks++; if (bus.apu_ready_o !== 1'b1) begin errors++; $display("FAIL colrr_apu_ready got=%0b exp=1", bus.apu_ready_o); end
        checks++; if (bus.lsu_ready_o !== 1'b0) begin errors++; $display("FAIL colrr_lsu_wait got=%0b exp=0", bus.lsu_ready_o); end
        @(negedge clk);
        checks++; if (bus.rf_we_b_o !== 1'b1 || bus.rf_waddr_b_o !== 6'd12) begin errors++; $display("FAIL colrr_apu_write got=%0b/%0h exp=1/c", bus.rf_we_b_o, bus.rf_waddr_b_o); end
        bus.apu_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.rf_we_b_o !== 1'b1 || bus.rf_waddr_b_o !== 6'd10) begin errors++; $display("FAIL colrr_lsu_write got=%0b/%0h exp=1/a", bus.rf_we_b_o, bus.rf_waddr_b_o); end
        idle();
`endif
    endtask

    task automatic test_illegal();
        @(negedge clk);
        bus.apu_valid_i = 1'b1; bus.apu_waddr_i = 6'h21; bus.apu_wdata_i = 32'h2121;
        bus.ex_we_i = 1'b1; bus.ex_waddr_i = 6'h21; bus.ex_wdata_i = 32'h4242;
        #1;
        checks++; if (bus.apu_ready_o !== 1'b1) begin errors++; $display("FAIL ill_apu_ready got=%0b exp=1", bus.apu_ready_o); end
        @(negedge clk);
        idle();
        bus.lsu_valid_i = 1'b1; bus.lsu_waddr_i = 6'd0; bus.lsu_wdata_i = 32'h1;
        checks++; if (bus.rf_we_b_o !== 1'b0)   begin errors++; $display("FAIL ill_fp_we_b got=%0b exp=0", bus.rf_we_b_o); end
        checks++; if (bus.rf_we_a_o !== 1'b0)   begin errors++; $display("FAIL ill_fp_we_a got=%0b exp=0", bus.rf_we_a_o); end
        checks++; if (bus.collision_o !== 1'b0) begin errors++; $display("FAIL ill_fp_collision got=%0b exp=0", bus.collision_o); end
        #1;
        checks++; if (bus.lsu_ready_o !== 1'b1) begin errors++; $display("FAIL ill_lsu_ready got=%0b exp=1", bus.lsu_ready_o); end
        @(negedge clk);
        idle();
        checks++; if (bus.rf_we_b_o !== 1'b0)   begin errors++; $display("FAIL ill_x0_we_b got=%0b exp=0", bus.rf_we_b_o); end
        checks++; if (bus.collision_o !== 1'b0) begin errors++; $display("FAIL ill_x0_collision got=%0b exp=0", bus.collision_o); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.ex_we_i = 1'b1; bus.ex_waddr_i = 6'(10 + i); bus.ex_wdata_i = 32'hE0 + i;
            bus.lsu_valid_i = 1'b1; bus.lsu_waddr_i = 6'(20 + i); bus.lsu_wdata_i = 32'hC0 + i;
            #1;
            checks++; if (bus.lsu_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got=%0b exp=1", i, bus.lsu_ready_o); end
            @(negedge clk);
            checks++; if (bus.rf_we_a_o !== 1'b1 || bus.rf_waddr_a_o !== 6'(10 + i) || bus.rf_wdata_a_o !== 32'hE0 + i) begin errors++; $display("FAIL b2b_port_a[%0d] got=%0b/%0h/%0h", i, bus.rf_we_a_o, bus.rf_waddr_a_o, bus.rf_wdata_a_o); end
            checks++; if (bus.rf_we_b_o !== 1'b1 || bus.rf_waddr_b_o !== 6'(20 + i) || bus.rf_wdata_b_o !== 32'hC0 + i) begin errors++; $display("FAIL b2b_port_b[%0d] got=%0b/%0h/%0h", i, bus.rf_we_b_o, bus.rf_waddr_b_o, bus.rf_wdata_b_o); end
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.lsu_valid_i = 1'b1; bus.lsu_waddr_i = 6'd3; bus.lsu_wdata_i = 32'h33;
        bus.apu_valid_i = 1'b1; bus.apu_waddr_i = 6'd4; bus.apu_wdata_i = 32'h44;
        #1;
        checks++; if (bus.lsu_ready_o !== 1'b1) begin errors++; $display("FAIL rmid_handshake got=%0b exp=1", bus.lsu_ready_o); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle();
        #1;
        checks++; if (bus.rf_we_b_o !== 1'b0)    begin errors++; $display("FAIL rmid_we_b got=%0b exp=0", bus.rf_we_b_o); end
        checks++; if (bus.rf_waddr_b_o !== 6'd0) begin errors++; $display("FAIL rmid_waddr_b got=%0h exp=0", bus.rf_waddr_b_o); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.rf_we_a_o !== 1'b0 || bus.rf_we_b_o !== 1'b0 || bus.collision_o !== 1'b0) begin errors++; $display("FAIL rmid_idle[%0d] got=%0b/%0b/%0b exp=0/0/0", i, bus.rf_we_a_o, bus.rf_we_b_o, bus.collision_o); end
        end
        bus.lsu_valid_i = 1'b1; bus.lsu_waddr_i = 6'd3; bus.lsu_wdata_i = 32'h333;
        bus.apu_valid_i = 1'b1; bus.apu_waddr_i = 6'd4; bus.apu_wdata_i = 32'h444;
        #1;
        checks++; if (bus.lsu_ready_o !== 1'b1) begin errors++; $display("FAIL rmid_flag_reset got=%0b exp=1", bus.lsu_ready_o); end
        @(negedge clk);
        idle();
        checks++; if (bus.rf_we_b_o !== 1'b1 || bus.rf_wdata_b_o !== 32'h333) begin errors++; $display("FAIL rmid_new_write got=%0b/%0h exp=1/333", bus.rf_we_b_o, bus.rf_wdata_b_o); end
        repeat (3) @(negedge clk);
    endtask

`ifdef CV32E40P_WB_ARB_APU_SKID_EN
    task automatic test_skid();
        int apu_sent = 0;
        int apu_seen = 0;
        @(negedge clk);
        bus.lsu_valid_i = 1'b1; bus.lsu_waddr_i = 6'd3; bus.lsu_wdata_i = 32'h33;
        for (int cyc = 0; cyc < 12; cyc++) begin
            bus.apu_valid_i = (apu_sent < 3);
            bus.apu_waddr_i = 6'(8 + apu_sent);
            bus.apu_wdata_i = 32'h800 + apu_sent;
            #1;
            if (cyc < 3) begin
                checks++; if (bus.apu_ready_o !== (cyc < 2)) begin errors++; $display("FAIL skid_ready[%0d] got=%0b exp=%0b", cyc, bus.apu_ready_o, cyc < 2); end
            end
            if (bus.apu_valid_i && bus.apu_ready_o) apu_sent++;
            @(negedge clk);
            if (bus.rf_we_b_o && bus.rf_waddr_b_o >= 6'd8) begin
                checks++; if (bus.rf_waddr_b_o !== 6'(8 + apu_seen)) begin errors++; $display("FAIL skid_order got=%0h exp=%0h", bus.rf_waddr_b_o, 6'(8 + apu_seen)); end
                apu_seen++;
            end
        end
        idle();
        checks++; if (apu_seen != 3) begin errors++; $display("FAIL skid_count got=%0d exp=3", apu_seen); end
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_lsu_only();
`ifdef CV32E40P_WB_ARB_APU_SKID_EN
        test_skid();
`else
        test_round_robin();
`endif
        test_collision();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
